// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizes for the writeback arbiter slice: data width,
// register count, register-index type and requester identifiers.
package wb_arbiter_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int IDX_W = $clog2(NREGS);

  typedef logic [IDX_W-1:0] reg_idx_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: two requesters (ALU, load unit), issue-side reservation,
// scoreboard queries and the register-file write port.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN = wb_arbiter_pkg::XLEN
) ();

  // Handshake: a transfer completes on any cycle where valid && ready.
  // ready never looks at its own requester's ready; a requester that sees
  // ready=0 keeps valid, rd and val stable until it is granted.
  logic            alu_valid;
  logic            alu_ready;
  reg_idx_t        alu_rd;
  logic [XLEN-1:0] alu_val;

  logic            mem_valid;
  logic            mem_ready;
  reg_idx_t        mem_rd;
  logic [XLEN-1:0] mem_val;

  logic            rsv_valid;
  reg_idx_t        rsv_rd;

  reg_idx_t        rs1;
  reg_idx_t        rs2;
  logic            rs1_busy;
  logic            rs2_busy;

  logic            write_sig;
  reg_idx_t        write_reg;
  logic [XLEN-1:0] write_val;

  req_id_t         dbg_prio;

  modport master (
    output alu_valid, alu_rd, alu_val,
    output mem_valid, mem_rd, mem_val,
    output rsv_valid, rsv_rd, rs1, rs2,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy,
    input  write_sig, write_reg, write_val, dbg_prio
  );

  modport slave (
    input  alu_valid, alu_rd, alu_val,
    input  mem_valid, mem_rd, mem_val,
    input  rsv_valid, rsv_rd, rs1, rs2,
    output alu_ready, mem_ready, rs1_busy, rs2_busy,
    output write_sig, write_reg, write_val, dbg_prio
  );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write busy bits, one per architectural register; x0 is never busy.
// A reservation and a clear of the same index in one cycle leave it busy.
module wb_scoreboard
  import wb_arbiter_pkg::*;
#(
  parameter int NREGS = wb_arbiter_pkg::NREGS
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t q1_idx,
  input  reg_idx_t q2_idx,
  output logic     q1_busy,
  output logic     q2_busy
);

  logic [NREGS-1:0] busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      if (clr_en) busy_q[clr_idx] <= 1'b0;
      // Later assignment wins, so the reservation overrides a same-index clear.
      if (set_en && (set_idx != '0)) busy_q[set_idx] <= 1'b1;
      busy_q[0] <= 1'b0;
    end
  end

  assign q1_busy = busy_q[q1_idx];
  assign q2_busy = busy_q[q2_idx];

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter between ALU and load writebacks feeding a registered
// register-file write port, with a busy-bit scoreboard for issue queries.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN  = wb_arbiter_pkg::XLEN,
  parameter int NREGS = wb_arbiter_pkg::NREGS
) (
  input  logic         clk,
  input  logic         reset,
  wb_arbiter_if.slave  bus
);

  req_id_t         prio_q;
  logic            contend;
  logic            grant_alu;
  logic            grant_mem;
  logic            grant;
  reg_idx_t        grant_rd;
  logic [XLEN-1:0] grant_val;

  logic            write_q;
  reg_idx_t        write_reg_q;
  logic [XLEN-1:0] write_val_q;

  always_comb begin
    contend   = bus.alu_valid && bus.mem_valid;
    grant_alu = !reset && bus.alu_valid && (!bus.mem_valid || (prio_q == REQ_ALU));
    grant_mem = !reset && bus.mem_valid && (!bus.alu_valid || (prio_q == REQ_MEM));
    grant     = grant_alu || grant_mem;
    grant_rd  = grant_mem ? bus.mem_rd  : bus.alu_rd;
    grant_val = grant_mem ? bus.mem_val : bus.alu_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q     <= 1'b0;
      write_reg_q <= '0;
      write_val_q <= '0;
      prio_q      <= REQ_ALU;
    end else begin
      // Writes to x0 still handshake but never reach the register file.
      write_q <= grant && (grant_rd != '0);
      if (grant) begin
        write_reg_q <= grant_rd;
        write_val_q <= grant_val;
      end
      if (contend) prio_q <= grant_alu ? REQ_MEM : REQ_ALU;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;
  // A write pending when reset rises is dropped in that same cycle.
  assign bus.write_sig = write_q && !reset;
  assign bus.write_reg = write_reg_q;
  assign bus.write_val = write_val_q;
  assign bus.dbg_prio  = prio_q;

  wb_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (bus.rsv_valid),
    .set_idx (bus.rsv_rd),
    .clr_en  (grant),
    .clr_idx (grant_rd),
    .q1_idx  (bus.rs1),
    .q2_idx  (bus.rs2),
    .q1_busy (bus.rs1_busy),
    .q2_busy (bus.rs2_busy)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// per-cycle comparison against a behavioural model of the arbitration rules.
module tb_wb_arbiter;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int W     = 5 + XLEN;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if #(.XLEN(XLEN)) bus ();

  wb_arbiter #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [W-1:0] exp_q[$];
  bit           m_busy [NREGS];
  int           m_last_winner;
  int           alu_wait;
  int           mem_wait;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
    m_last_winner = 1;
    alu_wait = 0;
    mem_wait = 0;
  end

  // Model: the requester that did not win the last contention wins the next.
  always @(negedge clk) begin
    logic         e_alu_rdy, e_mem_rdy, e_sig, have;
    logic [W-1:0] e;
    logic [4:0]   g_rd;
    logic [XLEN-1:0] g_val;
    e_alu_rdy = !reset && bus.alu_valid && (!bus.mem_valid || m_last_winner == 1);
    e_mem_rdy = !reset && bus.mem_valid && (!bus.alu_valid || m_last_winner == 0);
    chk("m_alu_ready", bus.alu_ready, e_alu_rdy);
    chk("m_mem_ready", bus.mem_ready, e_mem_rdy);

    have = 0;
    e = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      have = 1;
    end
    e_sig = have && !reset;
    chk("m_write_sig", bus.write_sig, e_sig);
    if (e_sig) begin
      chk("m_write_reg", bus.write_reg, e[W-1:XLEN]);
      chk("m_write_val", bus.write_val, e[XLEN-1:0]);
    end
    chk("m_rs1_busy", bus.rs1_busy, m_busy[bus.rs1]);
    chk("m_rs2_busy", bus.rs2_busy, m_busy[bus.rs2]);

    if (!reset) begin
      alu_wait = (bus.alu_valid && !bus.alu_ready) ? alu_wait + 1 : 0;
      mem_wait = (bus.mem_valid && !bus.mem_ready) ? mem_wait + 1 : 0;
      if (bus.alu_valid) chk("alu_starve", alu_wait > 1, 0);
      if (bus.mem_valid) chk("mem_starve", mem_wait > 1, 0);
    end else begin
      alu_wait = 0;
      mem_wait = 0;
    end

    if (reset) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 0;
      exp_q.delete();
      m_last_winner = 1;
    end else begin
      if (e_alu_rdy || e_mem_rdy) begin
        g_rd  = e_alu_rdy ? bus.alu_rd  : bus.mem_rd;
        g_val = e_alu_rdy ? bus.alu_val : bus.mem_val;
        if (g_rd != 0) exp_q.push_back({g_rd, g_val});
        m_busy[g_rd] = 0;
        if (bus.alu_valid && bus.mem_valid) m_last_winner = e_alu_rdy ? 0 : 1;
      end
      if (bus.rsv_valid && bus.rsv_rd != 0) m_busy[bus.rsv_rd] = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.rsv_valid = 1'b0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [XLEN-1:0] val);
    bus.alu_valid = 1'b1;
    bus.alu_rd    = rd;
    bus.alu_val   = val;
  endtask

  task automatic drive_mem(input logic [4:0] rd, input logic [XLEN-1:0] val);
    bus.mem_valid = 1'b1;
    bus.mem_rd    = rd;
    bus.mem_val   = val;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic alu_done, mem_done;
    reset = 1'b1;
    idle();
    bus.alu_rd = '0; bus.alu_val = '0;
    bus.mem_rd = '0; bus.mem_val = '0;
    bus.rsv_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    step();
    drive_alu(5'd1, 64'h11);
    drive_mem(5'd2, 64'h22);
    @(negedge clk);
    chk("rst_alu_ready", bus.alu_ready, 0);
    chk("rst_mem_ready", bus.mem_ready, 0);
    chk("rst_write_sig", bus.write_sig, 0);
    chk("rst_write_reg", bus.write_reg, 0);
    chk("rst_write_val", bus.write_val, 0);
    step();
    reset = 1'b0;
    idle();

    // Lone ALU request
    step();
    drive_alu(5'd5, 64'h1234);
    @(negedge clk);
    chk("lone_alu_ready", bus.alu_ready, 1);
    chk("lone_mem_ready", bus.mem_ready, 0);
    step();
    idle();
    @(negedge clk);
    chk("lone_write_sig", bus.write_sig, 1);
    chk("lone_write_reg", bus.write_reg, 5);
    chk("lone_write_val", bus.write_val, 64'h1234);

    // Contention: ALU first, MEM next cycle, then MEM wins the next contention
    step();
    drive_alu(5'd3, 64'hA3);
    drive_mem(5'd7, 64'hB7);
    @(negedge clk);
    chk("cont1_alu_ready", bus.alu_ready, 1);
    chk("cont1_mem_ready", bus.mem_ready, 0);
    step();
    bus.alu_valid = 1'b0;
    @(negedge clk);
    chk("cont1_mem_late", bus.mem_ready, 1);
    chk("cont1_wr_alu", bus.write_reg, 3);
    step();
    drive_alu(5'd4, 64'hA4);
    drive_mem(5'd8, 64'hB8);
    @(negedge clk);
    chk("cont2_wr_mem", bus.write_reg, 7);
    chk("cont2_wv_mem", bus.write_val, 64'hB7);
    chk("cont2_mem_ready", bus.mem_ready, 1);
    chk("cont2_alu_ready", bus.alu_ready, 0);
    step();
    bus.mem_valid = 1'b0;
    @(negedge clk);
    chk("cont2_alu_late", bus.alu_ready, 1);
    chk("cont2_wr_8", bus.write_reg, 8);
    step();
    idle();
    @(negedge clk);
    chk("cont2_wr_4", bus.write_reg, 4);

    // x0 write (with a reservation of x0 in the same cycle)
    step();
    drive_mem(5'd0, 64'hFFFF);
    bus.rsv_valid = 1'b1;
    bus.rsv_rd = 5'd0;
    bus.rs1 = 5'd0;
    @(negedge clk);
    chk("x0_mem_ready", bus.mem_ready, 1);
    step();
    idle();
    @(negedge clk);
    chk("x0_write_sig", bus.write_sig, 0);
    chk("x0_rs1_busy", bus.rs1_busy, 0);

    // Scoreboard set / clear / set-wins
    step();
    bus.rsv_valid = 1'b1;
    bus.rsv_rd = 5'd9;
    bus.rs1 = 5'd9;
    bus.rs2 = 5'd9;
    @(negedge clk);
    chk("sb_no_bypass", bus.rs1_busy, 0);
    step();
    bus.rsv_valid = 1'b0;
    @(negedge clk);
    chk("sb_set", bus.rs1_busy, 1);
    step();
    drive_alu(5'd9, 64'h99);
    @(negedge clk);
    chk("sb_clr_grant", bus.alu_ready, 1);
    chk("sb_still_busy", bus.rs1_busy, 1);
    step();
    idle();
    @(negedge clk);
    chk("sb_cleared", bus.rs1_busy, 0);
    chk("sb_wr_9", bus.write_reg, 9);
    step();
    bus.rsv_valid = 1'b1;
    bus.rsv_rd = 5'd9;
    step();
    bus.rsv_valid = 1'b0;
    @(negedge clk);
    chk("sb_reset_busy", bus.rs2_busy, 1);
    step();
    drive_alu(5'd9, 64'h9A);
    bus.rsv_valid = 1'b1;
    bus.rsv_rd = 5'd9;
    step();
    idle();
    @(negedge clk);
    chk("sb_set_wins", bus.rs1_busy, 1);
    chk("sb_set_wins_wr", bus.write_sig, 1);

    // Reset mid-write
    step();
    bus.rsv_valid = 1'b1;
    bus.rsv_rd = 5'd10;
    bus.rs2 = 5'd10;
    step();
    bus.rsv_valid = 1'b0;
    drive_alu(5'd6, 64'h66);
    @(negedge clk);
    chk("rmw_grant", bus.alu_ready, 1);
    chk("rmw_busy10", bus.rs2_busy, 1);
    step();
    reset = 1'b1;
    drive_mem(5'd11, 64'h77);
    @(negedge clk);
    chk("rmw_write_drop", bus.write_sig, 0);
    chk("rmw_alu_ready", bus.alu_ready, 0);
    chk("rmw_mem_ready", bus.mem_ready, 0);
    step();
    @(negedge clk);
    chk("rmw_busy9_clr", bus.rs1_busy, 0);
    chk("rmw_busy10_clr", bus.rs2_busy, 0);
    chk("rmw_write_sig2", bus.write_sig, 0);
    chk("rmw_alu_ready2", bus.alu_ready, 0);
    step();
    reset = 1'b0;
    idle();

    // After reset the pointer favours the ALU again
    step();
    drive_alu(5'd12, 64'hC12);
    drive_mem(5'd13, 64'hD13);
    @(negedge clk);
    chk("post_rst_alu", bus.alu_ready, 1);
    chk("post_rst_mem", bus.mem_ready, 0);
    step();
    bus.alu_valid = 1'b0;
    step();
    idle();

    // Random traffic respecting the hold-until-granted rule
    alu_done = 1'b0;
    mem_done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!bus.alu_valid || alu_done) begin
        bus.alu_valid = 1'($urandom_range(0, 1));
        bus.alu_rd    = 5'($urandom_range(0, 31));
        bus.alu_val   = {$urandom, $urandom};
      end
      if (!bus.mem_valid || mem_done) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_rd    = 5'($urandom_range(0, 31));
        bus.mem_val   = {$urandom, $urandom};
      end
      bus.rsv_valid = 1'($urandom_range(0, 1));
      bus.rsv_rd    = 5'($urandom_range(0, 31));
      bus.rs1       = 5'($urandom_range(0, 31));
      bus.rs2       = 5'($urandom_range(0, 31));
      @(negedge clk);
      alu_done = bus.alu_ready;
      mem_done = bus.mem_ready;
    end
    step();
    idle();
    step();
    step();

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning the register data width.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the architectural register count; the index width is log2(NREGS).
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-005 The block SHALL have port alu_valid / alu_ready, input / output, 1 each, the ALU writeback handshake.
REQ-006 The block SHALL have port alu_rd / alu_val, input, 5 / XLEN, the ALU destination index and data.
REQ-007 The block SHALL have port mem_valid / mem_ready, input / output, 1 each, the load writeback handshake.
REQ-008 The block SHALL have port mem_rd / mem_val, input, 5 / XLEN, the load destination index and data.
REQ-009 The block SHALL have port rsv_valid / rsv_rd, input, 1 / 5, the issue-side destination reservation.
REQ-010 The block SHALL have port rs1 / rs2, input, 5 each, the scoreboard query indices.
REQ-011 The block SHALL have port rs1_busy / rs2_busy, output, 1 each, meaning the queried register has a pending write.
REQ-012 The block SHALL have port write_sig / write_reg / write_val, output, 1 / 5 / XLEN, which drive the register-file write port.

Function
REQ-013 A requester handshake SHALL complete in any cycle where its valid and ready are both high.
REQ-014 ready SHALL be combinational from both valids and the priority pointer, and SHALL never depend on the requester's own ready.
REQ-015 If only one requester is valid, it SHALL be granted.
REQ-016 If both requesters are valid, the requester not granted last SHALL win (round-robin).
REQ-017 The priority pointer SHALL update only on a contended grant.
REQ-018 At most one grant SHALL occur per cycle; the loser's ready SHALL be 0 and it SHALL hold its valid, rd and val stable.
REQ-019 Write latency SHALL be one cycle: a grant in cycle N SHALL produce write_sig=1 with the registered rd and val in cycle N+1; write_sig SHALL otherwise be 0.
REQ-020 A granted write with rd=0 SHALL complete its handshake with write_sig held 0 in N+1.
REQ-021 The scoreboard SHALL keep one busy bit per register; entry 0 SHALL be constant 0.
REQ-022 rsv_valid=1 with rsv_rd!=0 SHALL set busy[rsv_rd] at the next edge.
REQ-023 A grant SHALL clear busy[rd] at the next edge.
REQ-024 Simultaneous set and clear of the same index SHALL leave the bit set (the reservation wins).
REQ-025 rs1_busy/rs2_busy SHALL be combinational reads of the registered busy bits; a same-cycle write in progress SHALL NOT be bypassed.
REQ-026 A grant to an index whose busy bit is 0 SHALL still be written, with no error flagged.
REQ-027 A contending requester SHALL wait no more than one cycle (starvation bound).

Reset
REQ-028 On reset, write_sig, write_reg, write_val and all busy bits SHALL go to 0, and the pointer SHALL favour the ALU.
REQ-029 While reset is high, alu_ready and mem_ready SHALL be 0.
REQ-030 A grant registered in the cycle before reset SHALL be discarded: write_sig=0 in the cycle after reset rises.

Structure
REQ-031 A shared package SHALL hold XLEN, NREGS, the register-index typedef and the requester-id enum (REQ_ALU, REQ_MEM).
REQ-032 The busy-bit array SHALL be a separate sub-module, wb_scoreboard, with set, clear and two query ports.
REQ-033 Arbitration and the output register SHALL reside in wb_arbiter.

Verification
REQ-034 Lone ALU request: alu_valid, rd=5, val=0x1234 in cycle N -> alu_ready=1 in N; write_sig=1, write_reg=5, write_val=0x1234 in N+1.
REQ-035 Contention: both valid, ALU rd=3, MEM rd=7 held -> ALU granted first, MEM granted the next cycle; the next contention goes to MEM first.
REQ-036 x0 write: mem_valid, rd=0 -> mem_ready=1, write_sig=0 in N+1, rs1_busy for rs1=0 stays 0.
REQ-037 Scoreboard: rsv rd=9 -> rs1_busy=1 for rs1=9 next cycle; an ALU write to rd=9 clears it one cycle after grant; a same-cycle rsv of rd=9 with the grant -> bit stays 1.
REQ-038 Reset mid-write: grant in cycle N, reset high in N+1 -> write_sig=0 in N+1, all busy bits 0, both ready signals 0 until reset drops.
